// File: rtl/rom_req_arbiter.sv
// Round-robin arbiter that funnels per-layer single-word ROM read requests
// onto one SDRAM read port, with a per-transaction timeout.
module rom_req_arbiter #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned AW    = 25,
    parameter int unsigned DW    = 16,
    parameter int unsigned TMO   = 255
) (
    input  logic                clk,
    input  logic                RESETn,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT*AW-1:0] req_addr,
    output logic [NPORT-1:0]    rdy,
    output logic [DW-1:0]       rdata,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic                mem_ack,
    input  logic [DW-1:0]       mem_data,
    output logic [7:0]          tmo_cnt
);

    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e           state;
    logic [NPORT-1:0] pending;
    logic [AW-1:0]    addr_q [NPORT];
    logic [PW-1:0]    last;
    logic [PW-1:0]    cur;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    pidx;
    logic             pick_vld;
    logic [7:0]       wait_cnt;

    // Search starts at the port after the last grant and wraps.
    always_comb begin
        pick     = '0;
        pidx     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 1; i <= NPORT; i++) begin
            pidx = PW'((32'(last) + i) % NPORT);
            if (!pick_vld && pending[pidx]) begin
                pick     = pidx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state    <= StIdle;
            pending  <= '0;
            last     <= PW'(NPORT - 1);
            cur      <= '0;
            rdy      <= '0;
            rdata    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            tmo_cnt  <= '0;
            wait_cnt <= '0;
            for (int unsigned i = 0; i < NPORT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            mem_req <= 1'b0;
            rdy     <= '0;

            // A request landing on the grant edge keeps its port pending with the new address.
            for (int unsigned i = 0; i < NPORT; i++) begin
                if (req[i]) begin
                    pending[i] <= 1'b1;
                    addr_q[i]  <= req_addr[i*AW +: AW];
                end else if (state == StIdle && pick_vld && pick == PW'(i)) begin
                    pending[i] <= 1'b0;
                end
            end

            case (state)
                StIdle: begin
                    if (pick_vld) begin
                        cur      <= pick;
                        last     <= pick;
                        mem_addr <= addr_q[pick];
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= StWait;
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        rdata <= mem_data;
                        rdy   <= NPORT'(1) << cur;
                        state <= StDone;
                    end else if (wait_cnt == 8'(TMO - 1)) begin
                        state <= StIdle;
                        if (tmo_cnt != 8'hff) begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_req_arbiter.sv
// Bench for rom_req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_rom_req_arbiter;

    localparam int NPORT = 4;
    localparam int AW    = 25;
    localparam int DW    = 16;
    localparam int TMO   = 255;

    logic                clk = 1'b0;
    logic                RESETn;
    logic [NPORT-1:0]    req;
    logic [NPORT*AW-1:0] req_addr;
    logic [NPORT-1:0]    rdy;
    logic [DW-1:0]       rdata;
    logic                mem_req;
    logic [AW-1:0]       mem_addr;
    logic                mem_ack;
    logic [DW-1:0]       mem_data;
    logic [7:0]          tmo_cnt;

    int checks = 0;
    int errors = 0;

    rom_req_arbiter #(
        .NPORT (NPORT),
        .AW    (AW),
        .DW    (DW),
        .TMO   (TMO)
    ) dut (
        .clk      (clk),
        .RESETn   (RESETn),
        .req      (req),
        .req_addr (req_addr),
        .rdy      (rdy),
        .rdata    (rdata),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .tmo_cnt  (tmo_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [NPORT*AW-1:0] pa(input int p, input logic [AW-1:0] a);
        logic [NPORT*AW-1:0] v;
        v = '0;
        v[p*AW +: AW] = a;
        return v;
    endfunction

    // Drive one cycle of inputs, clock it, and sample 1 ns after the edge.
    task automatic step(input logic [NPORT-1:0] r, input logic [NPORT*AW-1:0] ra,
                        input logic ack, input logic [DW-1:0] d);
        req = r; req_addr = ra; mem_ack = ack; mem_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        step('0, '0, 1'b0, '0);
        step('0, '0, 1'b0, '0);
        RESETn = 1'b1;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        step(4'hF, pa(1, 25'h123), 1'b1, 16'h5555);
        step(4'hF, pa(2, 25'h456), 1'b1, 16'hAAAA);
        checks++; if (rdy !== 4'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0000", rdy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (tmo_cnt !== 8'd0) begin errors++; $display("FAIL reset_tmo_cnt: got %0d want 0", tmo_cnt); end
        RESETn = 1'b1;
        step('0, '0, 1'b0, '0);
        step('0, '0, 1'b0, '0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_no_pending: got mem_req %b want 0", mem_req); end
    endtask

    task automatic test_single();
        step(4'b0100, pa(2, 25'h0A0012), 1'b0, '0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_early: got mem_req %b want 0", mem_req); end
        step('0, '0, 1'b0, '0);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_mem_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 25'h0A0012) begin errors++; $display("FAIL single_mem_addr: got %h want 0a0012", mem_addr); end
        step('0, '0, 1'b0, '0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_pulse: got mem_req %b want 0", mem_req); end
        checks++; if (mem_addr !== 25'h0A0012) begin errors++; $display("FAIL single_addr_hold: got %h want 0a0012", mem_addr); end
        step('0, '0, 1'b1, 16'hBEEF);
        checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy: got %b want 0100", rdy); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL single_rdata: got %h want beef", rdata); end
        step('0, '0, 1'b0, 16'h1234);
        checks++; if (rdy !== 4'b0) begin errors++; $display("FAIL single_rdy_clear: got %b want 0000", rdy); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL single_rdata_hold: got %h want beef", rdata); end
        step('0, '0, 1'b0, '0);
    endtask

    task automatic test_contention();
        int nreq;
        logic [NPORT*AW-1:0] ra;
        nreq = 0;
        do_reset();
        ra = pa(0, 25'h10) | pa(1, 25'h11) | pa(2, 25'h12) | pa(3, 25'h13);
        step(4'hF, ra, 1'b0, '0);
        for (int k = 0; k < NPORT; k++) begin
            step('0, '0, 1'b0, '0);
            if (mem_req === 1'b1) nreq++;
            checks++; if (mem_addr !== AW'(32'h10 + k)) begin errors++; $display("FAIL contention_addr%0d: got %h want %h", k, mem_addr, 32'h10 + k); end
            checks++; if (rdy !== 4'b0) begin errors++; $display("FAIL contention_rdy_early%0d: got %b want 0000", k, rdy); end
            step('0, '0, 1'b1, DW'(16'hC000 + k));
            checks++; if (rdy !== 4'(1 << k)) begin errors++; $display("FAIL contention_rdy%0d: got %b want %b", k, rdy, 4'(1 << k)); end
            checks++; if (rdata !== DW'(16'hC000 + k)) begin errors++; $display("FAIL contention_rdata%0d: got %h want %h", k, rdata, 16'hC000 + k); end
            step('0, '0, 1'b0, '0);
            if (mem_req === 1'b1) nreq++;
        end
        for (int k = 0; k < 4; k++) begin
            step('0, '0, 1'b0, '0);
            if (mem_req === 1'b1) nreq++;
        end
        checks++; if (nreq != 4) begin errors++; $display("FAIL contention_count: got %0d mem_req want 4", nreq); end
    endtask

    task automatic test_overwrite();
        int n1;
        n1 = 0;
        step(4'b0001, pa(0, 25'h50), 1'b0, '0);
        step('0, '0, 1'b0, '0);
        checks++; if (mem_addr !== 25'h50) begin errors++; $display("FAIL overwrite_port0: got %h want 050", mem_addr); end
        step(4'b0010, pa(1, 25'h100), 1'b0, '0);
        step(4'b0010, pa(1, 25'h200), 1'b0, '0);
        step('0, '0, 1'b1, 16'h0F0F);
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL overwrite_rdy0: got %b want 0001", rdy); end
        step('0, '0, 1'b0, '0);
        step('0, '0, 1'b0, '0);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h200) begin
            errors++; $display("FAIL overwrite_issue: got req %b addr %h want 1 200", mem_req, mem_addr);
        end
        step('0, '0, 1'b1, 16'h2222);
        checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL overwrite_rdy1: got %b want 0010", rdy); end
        for (int k = 0; k < 6; k++) begin
            step('0, '0, 1'b0, '0);
            if (mem_req === 1'b1) n1++;
        end
        checks++; if (n1 != 0) begin errors++; $display("FAIL overwrite_stale: got %0d extra mem_req want 0", n1); end
    endtask

    task automatic test_same_cycle();
        int pulses;
        pulses = 0;
        step(4'b0001, pa(0, 25'h2F0), 1'b0, '0);
        step(4'b0001, pa(0, 25'h300), 1'b0, '0);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h2F0) begin
            errors++; $display("FAIL same_first: got req %b addr %h want 1 2f0", mem_req, mem_addr);
        end
        step('0, '0, 1'b1, 16'h1111);
        if (rdy === 4'b0001) pulses++;
        step('0, '0, 1'b0, '0);
        step('0, '0, 1'b0, '0);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h300) begin
            errors++; $display("FAIL same_second: got req %b addr %h want 1 300", mem_req, mem_addr);
        end
        step('0, '0, 1'b1, 16'h3333);
        if (rdy === 4'b0001) pulses++;
        checks++; if (rdata !== 16'h3333) begin errors++; $display("FAIL same_rdata: got %h want 3333", rdata); end
        step('0, '0, 1'b0, '0);
        checks++; if (pulses != 2) begin errors++; $display("FAIL same_pulses: got %0d rdy[0] pulses want 2", pulses); end
    endtask

    task automatic test_timeout();
        int nrdy;
        nrdy = 0;
        step(4'b1000, pa(3, 25'h7), 1'b0, '0);
        step('0, '0, 1'b0, '0);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL timeout_issue: got mem_req %b want 1", mem_req); end
        for (int k = 0; k < TMO - 1; k++) begin
            step('0, '0, 1'b0, '0);
            if (rdy !== 4'b0) nrdy++;
        end
        checks++; if (tmo_cnt !== 8'd0) begin errors++; $display("FAIL timeout_early: got tmo_cnt %0d want 0", tmo_cnt); end
        step('0, '0, 1'b0, '0);
        checks++; if (tmo_cnt !== 8'd1) begin errors++; $display("FAIL timeout_cnt: got %0d want 1", tmo_cnt); end
        step('0, '0, 1'b1, 16'hDEAD);
        if (rdy !== 4'b0) nrdy++;
        step('0, '0, 1'b0, '0);
        if (rdy !== 4'b0) nrdy++;
        checks++; if (nrdy != 0) begin errors++; $display("FAIL timeout_rdy: got %0d rdy cycles want 0", nrdy); end
        checks++; if (rdata === 16'hDEAD) begin errors++; $display("FAIL timeout_stray_rdata: got %h want unchanged", rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout_idle: got mem_req %b want 0", mem_req); end
    endtask

    task automatic test_reset_in_wait();
        int n;
        n = 0;
        step(4'b0100, pa(2, 25'h44), 1'b0, '0);
        step(4'b0010, pa(1, 25'h55), 1'b0, '0);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 25'h44) begin
            errors++; $display("FAIL rstwait_issue: got req %b addr %h want 1 044", mem_req, mem_addr);
        end
        RESETn = 1'b0;
        step('0, '0, 1'b0, '0);
        RESETn = 1'b1;
        step('0, '0, 1'b1, 16'h9999);
        checks++; if (rdy !== 4'b0) begin errors++; $display("FAIL rstwait_rdy: got %b want 0000", rdy); end
        checks++; if (rdata !== '0 || mem_addr !== '0 || tmo_cnt !== 8'd0) begin
            errors++; $display("FAIL rstwait_outputs: got rdata %h addr %h tmo %0d want 0 0 0", rdata, mem_addr, tmo_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            step('0, '0, 1'b0, '0);
            if (mem_req === 1'b1 || rdy !== 4'b0) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL rstwait_pending: got %0d active cycles want 0", n); end
    endtask

    // Reference: one transaction at a time, round-robin from the last grant,
    // latest address per port wins, ack completes, then a one-cycle rest.
    task automatic test_random();
        bit                  m_pend [NPORT];
        logic [AW-1:0]       m_addr [NPORT];
        logic [AW-1:0]       m_maddr;
        logic [DW-1:0]       m_rdata;
        int                  m_last, m_g, m_tmo, wc;
        int                  busy, rest;
        logic                exp_mreq;
        logic [NPORT-1:0]    exp_rdy, r;
        logic [NPORT*AW-1:0] ra;
        logic                ack;
        logic [DW-1:0]       d;
        bit                  found;
        do_reset();
        for (int p = 0; p < NPORT; p++) begin m_pend[p] = 0; m_addr[p] = '0; end
        m_maddr = '0; m_rdata = '0; m_last = NPORT - 1; m_g = 0; m_tmo = 0;
        wc = 0; busy = 0; rest = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            r   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            ra  = {$urandom, $urandom, $urandom, $urandom};
            ack = ($urandom_range(0, 2) == 0);
            d   = DW'($urandom);
            step(r, ra, ack, d);
            exp_mreq = 1'b0;
            exp_rdy  = '0;
            if (rest != 0) begin
                rest = 0;
            end else if (busy != 0) begin
                if (ack) begin
                    m_rdata = d; exp_rdy = 4'(1 << m_g); busy = 0; rest = 1;
                end else begin
                    wc++;
                    if (wc == TMO) begin busy = 0; if (m_tmo < 255) m_tmo++; end
                end
            end else begin
                found = 0;
                for (int k = 1; k <= NPORT; k++) begin
                    int p;
                    p = (m_last + k) % NPORT;
                    if (!found && m_pend[p]) begin found = 1; m_g = p; end
                end
                if (found) begin
                    exp_mreq = 1'b1; m_maddr = m_addr[m_g]; m_pend[m_g] = 0;
                    m_last = m_g; busy = 1; wc = 0;
                end
            end
            for (int p = 0; p < NPORT; p++) begin
                if (r[p]) begin m_pend[p] = 1; m_addr[p] = ra[p*AW +: AW]; end
            end
            checks++; if (mem_req !== exp_mreq) begin errors++; $display("FAIL rand_mem_req cyc %0d: got %b want %b", cyc, mem_req, exp_mreq); end
            checks++; if (mem_addr !== m_maddr) begin errors++; $display("FAIL rand_mem_addr cyc %0d: got %h want %h", cyc, mem_addr, m_maddr); end
            checks++; if (rdy !== exp_rdy) begin errors++; $display("FAIL rand_rdy cyc %0d: got %b want %b", cyc, rdy, exp_rdy); end
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata cyc %0d: got %h want %h", cyc, rdata, m_rdata); end
            checks++; if (tmo_cnt !== 8'(m_tmo)) begin errors++; $display("FAIL rand_tmo cyc %0d: got %0d want %0d", cyc, tmo_cnt, m_tmo); end
        end
    endtask

    initial begin
        RESETn = 1'b0; req = '0; req_addr = '0; mem_ack = 1'b0; mem_data = '0;
        test_reset();
        test_single();
        test_contention();
        test_overwrite();
        test_same_cycle();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_req_arbiter.md
ROM_REQ_ARBITER -- requirements
Module: rom_req_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 4, number of layer requester ports.
REQ-002 SHALL have parameter AW, default 25, SDRAM word-address width.
REQ-003 SHALL have parameter DW, default 16, SDRAM data width.
REQ-004 SHALL have parameter TMO, default 255, WAIT-state timeout in clk cycles.
REQ-005 clk  input  1  system clock; every flop updates on its rising edge.
REQ-006 RESETn  input  1  reset, synchronous, active-low.
REQ-007 req  input  NPORT  per-port single-cycle request strobe (a layer's sdr_req).
REQ-008 req_addr  input  NPORT*AW  per-port address; port i uses bits [i*AW +: AW], valid in the cycle req[i] is high.
REQ-009 rdy  output  NPORT  per-port single-cycle data-valid strobe (a layer's sdr_rdy).
REQ-010 rdata  output  DW  shared read data, valid in the cycle any rdy bit is high (a layer's sdr_data).
REQ-011 mem_req  output  1  single-cycle read strobe to the SDRAM controller.
REQ-012 mem_addr  output  AW  read address, held stable from mem_req until the transaction ends.
REQ-013 mem_ack  input  1  single-cycle controller strobe; mem_data is valid in that cycle.
REQ-014 mem_data  input  DW  controller read data.
REQ-015 tmo_cnt  output  8  saturating count of timed-out transactions.

Function
REQ-016 SHALL keep, per port, a pending flag and an AW-bit address register; req[i] high SHALL set pending[i] and load req_addr[i] at that edge.
REQ-017 A new req[i] while pending[i] is already set SHALL overwrite the stored address; latest request wins, and the earlier one is never issued.
REQ-018 SHALL implement a three-state FSM: IDLE, WAIT, DONE.
REQ-019 IDLE: if any pending bit is set, SHALL grant one port, register mem_addr, pulse mem_req for one cycle, clear that pending bit, and enter WAIT; otherwise stay in IDLE.
REQ-020 Grant SHALL be round-robin: search starts at the port after the last granted port, wrapping from NPORT-1 to 0.
REQ-021 If req[g] arrives in the same cycle port g is granted, pending[g] SHALL remain set with the new address, and the request SHALL be issued as a separate later transaction.
REQ-022 WAIT: on mem_ack, SHALL register rdata<=mem_data, drive rdy[g]=1 for exactly one cycle, and enter DONE.
REQ-023 DONE SHALL last one cycle and then return to IDLE; back-to-back issue gap therefore SHALL be at least 2 cycles after the ack.
REQ-024 Latency: req sampled at edge E0 -> mem_req high after E1 when idle; mem_ack sampled at edge Ek -> rdy/rdata high after Ek.
REQ-025 mem_ack in IDLE or DONE SHALL be ignored, with no rdy and no state change.
REQ-026 WAIT SHALL count cycles; after TMO cycles without mem_ack it SHALL return to IDLE, drive no rdy, and increment tmo_cnt, which saturates at 255.
REQ-027 A port whose request is in flight SHALL still accept new req; the in-flight ack SHALL deliver the old data with rdy, and the new address SHALL be issued afterwards.
REQ-028 rdy SHALL be one-hot or zero; rdata SHALL hold its value between acks.

Reset
REQ-029 While RESETn=0: state IDLE, all pending flags cleared, round-robin pointer set so port 0 is searched first, rdy=0, mem_req=0, mem_addr=0, rdata=0, tmo_cnt=0, WAIT counter=0.
REQ-030 Reset mid-transaction SHALL abandon it with no rdy; a late mem_ack after reset SHALL be ignored per REQ-025.

Verification
REQ-031 Single: req[2] with addr 0x0A0012 -> mem_req one cycle later with mem_addr=0x0A0012; ack with data 0xBEEF -> rdy=4'b0100 and rdata=0xBEEF for one cycle.
REQ-032 Contention: req=4'b1111 in one cycle after reset -> grants in order 0,1,2,3; each rdy appears only after its own ack; 4 mem_req total.
REQ-033 Overwrite: req[1] with 0x100 and, while port 0 is in WAIT, req[1] with 0x200 -> only 0x200 is issued for port 1.
REQ-034 Same-cycle: req[0] with 0x300 in the cycle port 0 is granted with 0x2F0 -> 0x2F0 issued, then 0x300 issued later; two rdy[0] pulses.
REQ-035 Timeout: no mem_ack for 255 cycles -> FSM in IDLE, tmo_cnt=1, no rdy; a subsequent stray mem_ack produces no rdy.
REQ-036 Reset in WAIT: RESETn low for 1 cycle, then mem_ack -> no rdy, all outputs 0, pending cleared.
